arcade_input_ctrl: RTL and testbench
====================================

// Module: arcade_input_ctrl
// PURPOSE
//  Input conditioner between user_io and the phoenix core. Latches PS/2 key
//  events and ORs them with joystick_0/1. Applies the rotate mapping and
//  left/right SOCD resolution, shapes the coin input into a timed pulse,
//  and adds optional autofire. All core button inputs come from this block.
// PARAMETERS
//  COIN_PULSE     1100000  coin output high time, clk_sys cycles (~100 ms)
//  COIN_LOCKOUT   2200000  ignore window after pulse ends, cycles
//  AUTOFIRE_HALF  550000   autofire half-period, cycles
// PORTS
//  clk_sys        in   1  system clock (core pixel clock domain)
//  reset          in   1  synchronous, active-high
//  key_strobe     in   1  one-cycle valid for key_code/key_pressed
//  key_pressed    in   1  1=make, 0=break
//  key_code       in   8  PS/2 set-2 scan code
//  joystick_0     in   8  [0]R [1]L [2]D [3]U [4]fire [5]barrier
//  joystick_1     in   8  same layout
//  rotate_ctrl    in   1  0=rotated cab (U/D keys steer), 1=normal (L/R)
//  autofire_en    in   1  enable autofire on fire
//  btn_coin       out  1  shaped coin pulse
//  btn_start      out  2  [0]=1P (F1), [1]=2P (F2)
//  btn_left       out  1  SOCD-resolved left
//  btn_right      out  1  SOCD-resolved right
//  btn_fire       out  1  fire, autofire-modulated
//  btn_barrier    out  1  barrier/shield
// BEHAVIOUR
//  - Reset: all key latches, outputs, counters =0; coin FSM=IDLE; last_dir=0.
//  - Key latches: on key_strobe, the latch for the code takes key_pressed.
//    75 up, 72 down, 6B left, 74 right, 76 coin, 05 F1, 06 F2, 29 fire,
//    11 barrier. Other codes: no change. No update without strobe.
//  - Raw dirs, rotate_ctrl=0: L=down|j0[2]|j1[2], R=up|j0[3]|j1[3].
//    rotate_ctrl=1: L=left|j0[1]|j1[1], R=right|j0[0]|j1[0].
//  - SOCD: a rising edge of only L sets last_dir=L; of only R sets last_dir=R.
//    Both raw high -> only last_dir side is output. Both rise in the same
//    cycle -> both outputs 0 until one side releases.
//  - All outputs are registered: 1 cycle latency from the raw input / latch.
//  - Coin FSM IDLE/PULSE/LOCKOUT. Coin acts on the rising edge of the coin
//    latch only.
//    IDLE  -> PULSE on the edge; btn_coin=1 from the next cycle for exactly
//             COIN_PULSE cycles.
//    PULSE -> LOCKOUT at count end; btn_coin=0. Edges are ignored for
//             COIN_LOCKOUT cycles.
//    LOCKOUT -> IDLE. Holding ESC gives one pulse only.
//  - Fire raw = fire|j0[4]|j1[4].
//    autofire_en=0 -> btn_fire=raw.
//    autofire_en=1 and raw held -> btn_fire=1 for AUTOFIRE_HALF cycles, then
//    0 for AUTOFIRE_HALF cycles, repeating. First phase is high.
//    Raw release -> btn_fire=0 and counter cleared. Re-press restarts high.
//    Toggling autofire_en mid-hold clears the counter.
//  - Barrier = barrier|j0[5]|j1[5]. Start = F1/F2 latches.
//  - Counter widths: $clog2(max param + 1). Counters saturate, never wrap.
//  - Reset mid-pulse or mid-lockout: btn_coin=0 next cycle, FSM=IDLE.
// STRUCTURE
//  - arcade_input_pkg: key-code localparams, coin_state_t enum
//    {IDLE,PULSE,LOCKOUT}, joystick bit-index localparams.
//  - Sub-module coin_pulse_fsm (edge detect, pulse/lockout counters).
//    Latches, SOCD and autofire stay inline.
// TESTING (COIN_PULSE=4, COIN_LOCKOUT=6, AUTOFIRE_HALF=3)
//  1 strobe 76/make at t0, held -> btn_coin=1 for t0+2..t0+5, then 0;
//    no second pulse while held.
//  2 ESC make, break, make again during lockout -> single pulse;
//    re-press after lockout -> second 4-cycle pulse.
//  3 rotate_ctrl=1: j0[1]=1, then j0[0]=1 -> btn_left=1 then 0 with
//    btn_right=1; release j0[0] -> btn_left=1 again.
//  4 autofire_en=1, hold j1[4] 14 cycles -> btn_fire 1,1,1,0,0,0,1...;
//    release -> 0 next cycle.
//  5 strobe 29/make, then strobe 0x1C/break -> btn_fire stays 1;
//    strobe 29/break -> 0.
//  6 reset asserted mid-PULSE -> btn_coin=0, all outputs 0 next cycle;
//    after release, FSM=IDLE.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared constants for the phoenix input conditioner: PS/2 scan codes,
// joystick bit positions and the coin FSM state type.
package arcade_input_pkg;

  localparam logic [7:0] KEY_UP      = 8'h75;
  localparam logic [7:0] KEY_DOWN    = 8'h72;
  localparam logic [7:0] KEY_LEFT    = 8'h6B;
  localparam logic [7:0] KEY_RIGHT   = 8'h74;
  localparam logic [7:0] KEY_COIN    = 8'h76;
  localparam logic [7:0] KEY_F1      = 8'h05;
  localparam logic [7:0] KEY_F2      = 8'h06;
  localparam logic [7:0] KEY_FIRE    = 8'h29;
  localparam logic [7:0] KEY_BARRIER = 8'h11;

  localparam int JOY_R       = 0;
  localparam int JOY_L       = 1;
  localparam int JOY_D       = 2;
  localparam int JOY_U       = 3;
  localparam int JOY_FIRE    = 4;
  localparam int JOY_BARRIER = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    LOCKOUT = 2'd2
  } coin_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/coin_pulse_fsm.sv
// Turns the rising edge of the coin key latch into a fixed-length pulse,
// followed by a lockout window during which further edges are ignored.
module coin_pulse_fsm
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE   = 1100000,
  parameter int COIN_LOCKOUT = 2200000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       coin_level,
  output logic       coin_pulse,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(max2(COIN_PULSE, COIN_LOCKOUT) + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(COIN_LOCKOUT - 1);

  coin_state_t   state;
  coin_state_t   state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          coin_prev;
  logic          coin_rise;

  assign coin_rise = coin_level & ~coin_prev;
  assign state_dbg = state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      coin_prev  <= 1'b0;
      coin_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      coin_prev  <= coin_level;
      coin_pulse <= (state_next == PULSE);
    end
  end

  // cnt counts cycles already spent in the current timed state; it only
  // increments below its terminal value, so it can never wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (coin_rise) begin
          state_next = PULSE;
          cnt_next   = '0;
        end
      end
      PULSE: begin
        if (cnt >= PULSE_LAST) begin
          state_next = LOCKOUT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LOCKOUT: begin
        if (cnt >= LOCK_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Input conditioner for the phoenix core: PS/2 key latches merged with both
// joysticks, rotate mapping, left/right SOCD, coin pulse shaping, autofire.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE    = 1100000,
  parameter int COIN_LOCKOUT  = 2200000,
  parameter int AUTOFIRE_HALF = 550000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       key_strobe,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  input  logic [7:0] joystick_0,
  input  logic [7:0] joystick_1,
  input  logic       rotate_ctrl,
  input  logic       autofire_en,
  output logic       btn_coin,
  output logic [1:0] btn_start,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_fire,
  output logic       btn_barrier,
  output logic [1:0] coin_state
);

  localparam int AW = $clog2(AUTOFIRE_HALF + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_HALF - 1);

  logic k_up, k_down, k_left, k_right, k_coin, k_f1, k_f2, k_fire, k_barrier;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      k_up      <= 1'b0;
      k_down    <= 1'b0;
      k_left    <= 1'b0;
      k_right   <= 1'b0;
      k_coin    <= 1'b0;
      k_f1      <= 1'b0;
      k_f2      <= 1'b0;
      k_fire    <= 1'b0;
      k_barrier <= 1'b0;
    end else if (key_strobe) begin
      case (key_code)
        KEY_UP:      k_up      <= key_pressed;
        KEY_DOWN:    k_down    <= key_pressed;
        KEY_LEFT:    k_left    <= key_pressed;
        KEY_RIGHT:   k_right   <= key_pressed;
        KEY_COIN:    k_coin    <= key_pressed;
        KEY_F1:      k_f1      <= key_pressed;
        KEY_F2:      k_f2      <= key_pressed;
        KEY_FIRE:    k_fire    <= key_pressed;
        KEY_BARRIER: k_barrier <= key_pressed;
        default: ;
      endcase
    end
  end

  // Rotated cabinet: the up/down controls steer the ship.
  logic raw_left, raw_right, raw_fire, raw_barrier;

  assign raw_left = rotate_ctrl
      ? (k_left | joystick_0[JOY_L] | joystick_1[JOY_L])
      : (k_down | joystick_0[JOY_D] | joystick_1[JOY_D]);
  assign raw_right = rotate_ctrl
      ? (k_right | joystick_0[JOY_R] | joystick_1[JOY_R])
      : (k_up    | joystick_0[JOY_U] | joystick_1[JOY_U]);
  assign raw_fire    = k_fire    | joystick_0[JOY_FIRE]    | joystick_1[JOY_FIRE];
  assign raw_barrier = k_barrier | joystick_0[JOY_BARRIER] | joystick_1[JOY_BARRIER];

  logic unused_joy;
  assign unused_joy = ^{joystick_0[7:6], joystick_1[7:6]};

  // SOCD: the most recently pressed side wins; a simultaneous press of both
  // sides (tie) blanks both until either one is released.
  logic prev_left, prev_right, last_right, tie;
  logic rise_left, rise_right, both_held, dir_right, hold_tie;
  logic left_next, right_next;

  always_comb begin
    rise_left  = raw_left & ~prev_left;
    rise_right = raw_right & ~prev_right;
    both_held  = raw_left & raw_right;
    hold_tie   = tie | (rise_left & rise_right);
    dir_right  = last_right;
    if (rise_right && !rise_left) dir_right = 1'b1;
    if (rise_left && !rise_right) dir_right = 1'b0;
    left_next  = raw_left  & ~(both_held & (hold_tie |  dir_right));
    right_next = raw_right & ~(both_held & (hold_tie | ~dir_right));
  end

  // Autofire: af_cnt counts cycles within the current half-period, af_low
  // marks the low half. Released fire or disabled autofire restarts high.
  logic [AW-1:0] af_cnt, af_cnt_next;
  logic          af_low, af_low_next, fire_next;

  always_comb begin
    af_cnt_next = '0;
    af_low_next = 1'b0;
    fire_next   = raw_fire;
    if (raw_fire && autofire_en) begin
      fire_next = ~af_low;
      if (af_cnt >= AF_LAST) begin
        af_cnt_next = '0;
        af_low_next = ~af_low;
      end else begin
        af_cnt_next = af_cnt + 1'b1;
        af_low_next = af_low;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_left   <= 1'b0;
      prev_right  <= 1'b0;
      last_right  <= 1'b0;
      tie         <= 1'b0;
      af_cnt      <= '0;
      af_low      <= 1'b0;
      btn_left    <= 1'b0;
      btn_right   <= 1'b0;
      btn_fire    <= 1'b0;
      btn_barrier <= 1'b0;
      btn_start   <= 2'b00;
    end else begin
      prev_left   <= raw_left;
      prev_right  <= raw_right;
      last_right  <= dir_right;
      tie         <= both_held & hold_tie;
      af_cnt      <= af_cnt_next;
      af_low      <= af_low_next;
      btn_left    <= left_next;
      btn_right   <= right_next;
      btn_fire    <= fire_next;
      btn_barrier <= raw_barrier;
      btn_start   <= {k_f2, k_f1};
    end
  end

  coin_pulse_fsm #(
    .COIN_PULSE   (COIN_PULSE),
    .COIN_LOCKOUT (COIN_LOCKOUT)
  ) u_coin (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .coin_level (k_coin),
    .coin_pulse (btn_coin),
    .state_dbg  (coin_state)
  );

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios followed by random traffic,
// every cycle compared with a timestamp/arithmetic reference model.
module tb_arcade_input_ctrl;
  import arcade_input_pkg::*;

  localparam int P = 4;
  localparam int L = 6;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_strobe, key_pressed;
  logic [7:0] key_code, joystick_0, joystick_1;
  logic       rotate_ctrl, autofire_en;
  logic       btn_coin, btn_left, btn_right, btn_fire, btn_barrier;
  logic [1:0] btn_start, coin_state;

  always #5 clk = ~clk;

  arcade_input_ctrl #(
    .COIN_PULSE    (P),
    .COIN_LOCKOUT  (L),
    .AUTOFIRE_HALF (H)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .key_strobe  (key_strobe),
    .key_pressed (key_pressed),
    .key_code    (key_code),
    .joystick_0  (joystick_0),
    .joystick_1  (joystick_1),
    .rotate_ctrl (rotate_ctrl),
    .autofire_en (autofire_en),
    .btn_coin    (btn_coin),
    .btn_start   (btn_start),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_fire    (btn_fire),
    .btn_barrier (btn_barrier),
    .coin_state  (coin_state)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: key levels by scan code, press timestamps for
  // SOCD, accepted coin pulse start time, length of the current autofire run.
  bit   mlat[256];
  int   ps;
  bit   ps_valid;
  bit   m_coin_prev, m_pl, m_pr;
  int   m_tl, m_tr, m_run;
  logic e_coin, e_left, e_right, e_fire, e_bar;
  logic [1:0] e_start, e_state;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mlat[i] = 1'b0;
    ps = 0; ps_valid = 1'b0; m_coin_prev = 1'b0;
    m_pl = 1'b0; m_pr = 1'b0; m_tl = -1; m_tr = -1; m_run = 0;
  endtask

  // Computes what the DUT must show after the coming clock edge.
  task automatic model_eval();
    bit rl, rr, c, f;
    int d;
    if (reset) begin
      model_clear();
      e_coin = 0; e_left = 0; e_right = 0; e_fire = 0; e_bar = 0;
      e_start = 2'b00; e_state = IDLE;
    end else begin
      rl = rotate_ctrl ? (mlat[8'h6B] | joystick_0[1] | joystick_1[1])
                       : (mlat[8'h72] | joystick_0[2] | joystick_1[2]);
      rr = rotate_ctrl ? (mlat[8'h74] | joystick_0[0] | joystick_1[0])
                       : (mlat[8'h75] | joystick_0[3] | joystick_1[3]);
      if (rl && !m_pl) m_tl = cyc;
      if (rr && !m_pr) m_tr = cyc;
      if (rl && rr) begin
        e_left  = (m_tl > m_tr);
        e_right = (m_tr > m_tl);
      end else begin
        e_left  = rl;
        e_right = rr;
      end
      m_pl = rl; m_pr = rr;

      c = mlat[8'h76];
      if (c && !m_coin_prev && (!ps_valid || cyc >= ps + P + L + 1)) begin
        ps = cyc;
        ps_valid = 1'b1;
      end
      m_coin_prev = c;
      d = cyc - ps;
      e_coin  = ps_valid && (d < P);
      e_state = !ps_valid ? IDLE : (d < P) ? PULSE : (d < P + L) ? LOCKOUT : IDLE;

      f = mlat[8'h29] | joystick_0[4] | joystick_1[4];
      if (f && autofire_en) begin
        e_fire = ((m_run / H) % 2) == 0;
        m_run++;
      end else begin
        e_fire = f;
        m_run  = 0;
      end

      e_bar   = mlat[8'h11] | joystick_0[5] | joystick_1[5];
      e_start = {mlat[8'h06], mlat[8'h05]};
      if (key_strobe) mlat[key_code] = key_pressed;
    end
    cyc++;
  endtask

  task automatic check_all();
    check("coin",    8'(btn_coin),    8'(e_coin));
    check("start",   8'(btn_start),   8'(e_start));
    check("left",    8'(btn_left),    8'(e_left));
    check("right",   8'(btn_right),   8'(e_right));
    check("fire",    8'(btn_fire),    8'(e_fire));
    check("barrier", 8'(btn_barrier), 8'(e_bar));
    check("state",   8'(coin_state),  8'(e_state));
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic key(input logic [7:0] code, input logic pressed);
    key_strobe = 1'b1; key_code = code; key_pressed = pressed;
    cycle();
    key_strobe = 1'b0; key_code = 8'h00; key_pressed = 1'b0;
  endtask

  logic [7:0]  codes[10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h76,
                             8'h05, 8'h06, 8'h29, 8'h11, 8'h1C};
  logic [13:0] af_pat = 14'b11100011100011;
  int          coin_hi;

  initial begin
    reset = 1'b1; key_strobe = 1'b0; key_pressed = 1'b0; key_code = 8'h00;
    joystick_0 = 8'h00; joystick_1 = 8'h00; rotate_ctrl = 1'b0; autofire_en = 1'b0;
    model_clear();
    idle(2);
    check("rst_outs", {btn_coin, btn_start, btn_left, btn_right, btn_fire,
                       btn_barrier, 1'b0}, 8'h00);
    reset = 1'b0;
    idle(1);

    // Coin make held: pulse visible t0+2..t0+5, then nothing while held.
    key(8'h76, 1'b1);
    check("t1_c1", 8'(btn_coin), 8'h00);
    for (int i = 2; i <= 16; i++) begin
      cycle();
      check("t1_pulse", 8'(btn_coin), (i >= 2 && i <= 5) ? 8'h01 : 8'h00);
    end

    // Re-press inside lockout is swallowed; re-press after lockout pulses.
    key(8'h76, 1'b0);
    idle(3);
    coin_hi = 0;
    key(8'h76, 1'b1); coin_hi += int'(btn_coin);
    repeat (2) begin cycle(); coin_hi += int'(btn_coin); end
    key(8'h76, 1'b0); coin_hi += int'(btn_coin);
    cycle(); coin_hi += int'(btn_coin);
    key(8'h76, 1'b1); coin_hi += int'(btn_coin);
    repeat (12) begin cycle(); coin_hi += int'(btn_coin); end
    check("t2_single", 8'(coin_hi), 8'd4);
    key(8'h76, 1'b0); coin_hi += int'(btn_coin);
    repeat (2) begin cycle(); coin_hi += int'(btn_coin); end
    key(8'h76, 1'b1); coin_hi += int'(btn_coin);
    repeat (8) begin cycle(); coin_hi += int'(btn_coin); end
    check("t2_second", 8'(coin_hi), 8'd8);
    key(8'h76, 1'b0);
    idle(2);

    // SOCD with normal orientation.
    rotate_ctrl = 1'b1;
    joystick_0 = 8'h02; idle(2);
    check("t3_l", {6'b0, btn_left, btn_right}, 8'h02);
    joystick_0 = 8'h03; idle(2);
    check("t3_r", {6'b0, btn_left, btn_right}, 8'h01);
    joystick_0 = 8'h02; idle(2);
    check("t3_l2", {6'b0, btn_left, btn_right}, 8'h02);
    joystick_0 = 8'h00; idle(1);
    joystick_0 = 8'h03; idle(2);
    check("t3_tie", {6'b0, btn_left, btn_right}, 8'h00);
    joystick_0 = 8'h01; idle(1);
    check("t3_untie", {6'b0, btn_left, btn_right}, 8'h01);
    joystick_0 = 8'h00; idle(1);
    rotate_ctrl = 1'b0;

    // Autofire on player-2 fire.
    autofire_en = 1'b1;
    joystick_1 = 8'h10;
    for (int i = 0; i < 14; i++) begin
      cycle();
      check("t4_af", 8'(btn_fire), 8'(af_pat[13-i]));
    end
    joystick_1 = 8'h00;
    cycle();
    check("t4_rel", 8'(btn_fire), 8'h00);
    autofire_en = 1'b0;

    // Fire key latch ignores an unrelated break code.
    key(8'h29, 1'b1); idle(1);
    check("t5_make", 8'(btn_fire), 8'h01);
    key(8'h1C, 1'b0); idle(1);
    check("t5_other", 8'(btn_fire), 8'h01);
    key(8'h29, 1'b0); idle(1);
    check("t5_break", 8'(btn_fire), 8'h00);

    // Reset in the middle of a coin pulse.
    joystick_0 = 8'h30;
    key(8'h76, 1'b1); idle(2);
    check("t6_pulse", 8'(btn_coin), 8'h01);
    reset = 1'b1;
    cycle();
    check("t6_outs", {btn_coin, btn_start, btn_left, btn_right, btn_fire,
                      btn_barrier, 1'b0}, 8'h00);
    check("t6_state", 8'(coin_state), 8'(IDLE));
    reset = 1'b0; joystick_0 = 8'h00;
    idle(2);
    check("t6_idle", 8'(coin_state), 8'(IDLE));

    // Random traffic against the model.
    for (int i = 0; i < 700; i++) begin
      int b;
      key_strobe  = ($urandom_range(0, 3) == 0);
      key_code    = codes[$urandom_range(0, 9)];
      key_pressed = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 7);
        joystick_0[b] = ~joystick_0[b];
      end
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 7);
        joystick_1[b] = ~joystick_1[b];
      end
      if ($urandom_range(0, 39) == 0) rotate_ctrl = ~rotate_ctrl;
      if ($urandom_range(0, 29) == 0) autofire_en = ~autofire_en;
      reset = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0; key_strobe = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
